// File: rtl/prism_in_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prism_in_cond_pkg
//  Description : Shared defaults and edge-classification helpers for the
//                PRISM input conditioner.
//  Contents    : PRISM_IN_WIDTH, PRISM_IN_CNT_W, edge_kind_t, edge_enabled()
//  Revision    : 1.0 - initial release
// ============================================================================
package prism_in_cond_pkg;

    localparam int PRISM_IN_WIDTH = 8;
    localparam int PRISM_IN_CNT_W = 4;

    // Kind of transition the debounced level is about to make this cycle.
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_t;

    // True when the given transition kind is enabled for event reporting.
    function automatic logic edge_enabled(input edge_kind_t kind,
                                          input logic       rise_en,
                                          input logic       fall_en);
        return ((kind == EDGE_RISE) && rise_en) ||
               ((kind == EDGE_FALL) && fall_en);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prism_in_cond_bit.sv
`default_nettype none
// ============================================================================
//  Module      : prism_in_cond_bit
//  Description : One conditioned input channel: 2-flop synchronizer,
//                mismatch-run debounce counter, filtered level and
//                enabled edge pulse.
//  Ports       : clk, rst        - clock / synchronous active-high reset
//                din             - raw asynchronous pin
//                thresh          - debounce threshold N
//                rise_en/fall_en - edge event enables
//                filt_out        - debounced level (registered)
//                edge_pulse      - one-cycle enabled edge event (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module prism_in_cond_bit
    import prism_in_cond_pkg::*;
#(
    parameter int CNT_W = PRISM_IN_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [CNT_W-1:0] thresh,
    input  logic             rise_en,
    input  logic             fall_en,
    output logic             filt_out,
    output logic             edge_pulse
);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;
    logic             r_pulse;

    logic             w_mismatch;
    logic             w_toggle;
    edge_kind_t       w_kind;

    assign w_mismatch = (r_sync2 != r_filt);
    // ">=" rather than "==" so a threshold lowered below the running count
    // still fires on the next mismatch cycle; the count also never wraps
    // because it only increments while below the threshold.
    assign w_toggle   = w_mismatch && (r_cnt >= thresh);

    always_comb begin
        w_kind = EDGE_NONE;
        if (w_toggle) begin
            w_kind = r_filt ? EDGE_FALL : EDGE_RISE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_filt  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            // Pulse is registered alongside the filter flop so both change
            // on the same edge.
            r_pulse <= edge_enabled(w_kind, rise_en, fall_en);
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_filt <= ~r_filt;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign filt_out   = r_filt;
    assign edge_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/prism_in_cond.sv
`default_nettype none
// ============================================================================
//  Module      : prism_in_cond
//  Description : PRISM input conditioner. WIDTH independent channels, each
//                synchronized and debounced, with per-bit edge events,
//                sticky edge flags (write-1-to-clear) and an interrupt.
//  Ports       : clk, rst      - clock / synchronous active-high reset
//                din           - raw asynchronous pins
//                cfg_thresh    - debounce threshold N (shared by all bits)
//                cfg_rise_en   - per-bit rising-edge event enable
//                cfg_fall_en   - per-bit falling-edge event enable
//                flag_clr      - per-bit clear pulse for edge_flags
//                filt_out      - debounced levels
//                edge_pulse    - one-cycle enabled edge events
//                edge_flags    - sticky captured edge events
//                irq           - OR of edge_flags (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module prism_in_cond
    import prism_in_cond_pkg::*;
#(
    parameter int WIDTH = PRISM_IN_WIDTH,
    parameter int CNT_W = PRISM_IN_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic [WIDTH-1:0] cfg_rise_en,
    input  logic [WIDTH-1:0] cfg_fall_en,
    input  logic [WIDTH-1:0] flag_clr,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] edge_pulse,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq
);

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_pulse;
    logic [WIDTH-1:0] r_flags;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        prism_in_cond_bit #(
            .CNT_W (CNT_W)
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .din        (din[gi]),
            .thresh     (cfg_thresh),
            .rise_en    (cfg_rise_en[gi]),
            .fall_en    (cfg_fall_en[gi]),
            .filt_out   (w_filt[gi]),
            .edge_pulse (w_pulse[gi])
        );
    end

    // A new event and a clear on the same bit in the same cycle: the OR of
    // the pulse is applied after masking, so the set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~flag_clr) | w_pulse;
        end
    end

    assign filt_out   = w_filt;
    assign edge_pulse = w_pulse;
    assign edge_flags = r_flags;
    assign irq        = |r_flags;

endmodule
`default_nettype wire

// File: tb/tb_prism_in_cond.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prism_in_cond
//  Description : Self-checking bench for prism_in_cond: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prism_in_cond;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [W-1:0]  din;
    logic [CW-1:0] cfg_thresh;
    logic [W-1:0]  cfg_rise_en;
    logic [W-1:0]  cfg_fall_en;
    logic [W-1:0]  flag_clr;
    logic [W-1:0]  filt_out;
    logic [W-1:0]  edge_pulse;
    logic [W-1:0]  edge_flags;
    logic          irq;

    int n_checks = 0;
    int n_errors = 0;

    prism_in_cond #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .cfg_thresh  (cfg_thresh),
        .cfg_rise_en (cfg_rise_en),
        .cfg_fall_en (cfg_fall_en),
        .flag_clr    (flag_clr),
        .filt_out    (filt_out),
        .edge_pulse  (edge_pulse),
        .edge_flags  (edge_flags),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Pin samples from the last two edges stand in for the synchronizer;
    // a debounced level changes once the synchronized pin has disagreed
    // with it for more than N consecutive cycles.
    logic [W-1:0] m_d1, m_d2;
    logic [W-1:0] m_filt, m_pulse, m_flags;
    int           m_run [W];

    task automatic model_edge(input logic r, input logic [W-1:0] d,
                              input int n, input logic [W-1:0] re,
                              input logic [W-1:0] fe, input logic [W-1:0] clr);
        logic [W-1:0] new_pulse;
        if (r) begin
            m_d1 = '0; m_d2 = '0; m_filt = '0; m_pulse = '0; m_flags = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            new_pulse = '0;
            for (int i = 0; i < W; i++) begin
                if (m_d2[i] == m_filt[i]) begin
                    m_run[i] = 0;
                end else if (m_run[i] >= n) begin
                    m_filt[i]    = ~m_filt[i];
                    m_run[i]     = 0;
                    new_pulse[i] = m_filt[i] ? re[i] : fe[i];
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end
            m_flags = (m_flags & ~clr) | m_pulse;
            m_pulse = new_pulse;
            m_d2    = m_d1;
            m_d1    = d;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, advance the model, compare.
    task automatic step(input logic r, input logic [W-1:0] d,
                        input logic [CW-1:0] th, input logic [W-1:0] re,
                        input logic [W-1:0] fe, input logic [W-1:0] clr);
        rst = r; din = d; cfg_thresh = th;
        cfg_rise_en = re; cfg_fall_en = fe; flag_clr = clr;
        @(posedge clk);
        model_edge(r, d, int'(th), re, fe, clr);
        #1;
        check("filt_out",   32'(filt_out),   32'(m_filt));
        check("edge_pulse", 32'(edge_pulse), 32'(m_pulse));
        check("edge_flags", 32'(edge_flags), 32'(m_flags));
        check("irq",        32'(irq),        32'(|m_flags));
    endtask

    task automatic do_reset(input logic [W-1:0] d);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, d, 4'd0, '0, '0, '0);
            check("rst_outs", 32'({filt_out, edge_pulse, edge_flags, irq}), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] r_re, r_fe, r_clr;
        logic [CW-1:0] r_th;
        logic          r_rst;

        rst = 1'b1; din = '0; cfg_thresh = '0;
        cfg_rise_en = '0; cfg_fall_en = '0; flag_clr = '0;
        m_d1 = '0; m_d2 = '0; m_filt = '0; m_pulse = '0; m_flags = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;

        // S1: N=3, bit 0 rises; pin first sampled at step 0 -> filter at 5
        do_reset('0);
        for (int j = 0; j < 2; j++) step(1'b0, '0, 4'd3, 8'h01, '0, '0);
        for (int j = 0; j < 9; j++) begin
            step(1'b0, 8'h01, 4'd3, 8'h01, '0, '0);
            check("s1_filt0",  32'(filt_out[0]),   32'(j >= 5));
            check("s1_pulse0", 32'(edge_pulse[0]), 32'(j == 5));
            check("s1_flag0",  32'(edge_flags[0]), 32'(j >= 6));
            check("s1_irq",    32'(irq),           32'(j >= 6));
        end

        // S2: N=3, a glitch of N cycles is filtered; N+1 cycles passes
        do_reset('0);
        for (int j = 0; j < 10; j++) begin
            d = (j < 3) ? 8'h04 : 8'h00;
            step(1'b0, d, 4'd3, 8'h04, 8'h04, '0);
            check("s2_short_filt2",  32'(filt_out[2]),   32'd0);
            check("s2_short_pulse2", 32'(edge_pulse[2]), 32'd0);
        end
        for (int j = 0; j < 8; j++) begin
            d = (j < 4) ? 8'h04 : 8'h00;
            step(1'b0, d, 4'd3, 8'h04, 8'h04, '0);
            check("s2_long_filt2",  32'(filt_out[2]),   32'(j >= 5));
            check("s2_long_pulse2", 32'(edge_pulse[2]), 32'(j == 5));
        end

        // S3: N=0, fall-only on bit 5, 6-cycle pin pulse
        do_reset('0);
        for (int j = 0; j < 12; j++) begin
            d = (j < 6) ? 8'h20 : 8'h00;
            step(1'b0, d, 4'd0, 8'h00, 8'h20, '0);
            check("s3_filt5",  32'(filt_out[5]),   32'((j >= 2) && (j <= 7)));
            check("s3_pulse5", 32'(edge_pulse[5]), 32'(j == 8));
            check("s3_flag5",  32'(edge_flags[5]), 32'(j >= 9));
        end

        // S4: clear coinciding with a new event on bit 1, then clear alone
        do_reset('0);
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 8'h02, 4'd0, 8'h02, '0, (j >= 3) ? 8'h02 : 8'h00);
            if (j == 2) check("s4_pulse1", 32'(edge_pulse[1]), 32'd1);
            if (j == 3) check("s4_setwins", 32'(edge_flags[1]), 32'd1);
            if (j == 4) begin
                check("s4_cleared", 32'(edge_flags[1]), 32'd0);
                check("s4_irq",     32'(irq),           32'd0);
            end
        end

        // S5: count reaches 10 under N=15, then N drops to 4
        do_reset('0);
        for (int j = 0; j < 12; j++) begin
            step(1'b0, 8'h08, 4'd15, 8'h08, '0, '0);
            check("s5_hold_filt3", 32'(filt_out[3]), 32'd0);
        end
        step(1'b0, 8'h08, 4'd4, 8'h08, '0, '0);
        check("s5_drop_filt3",  32'(filt_out[3]),   32'd1);
        check("s5_drop_pulse3", 32'(edge_pulse[3]), 32'd1);
        step(1'b0, 8'h08, 4'd4, 8'h08, '0, '0);
        check("s5_after_filt3", 32'(filt_out[3]),   32'd1);
        check("s5_after_pulse", 32'(edge_pulse[3]), 32'd0);

        // S6: all pins high through reset, N=2
        do_reset(8'hFF);
        for (int j = 0; j < 7; j++) begin
            step(1'b0, 8'hFF, 4'd2, 8'hFF, '0, '0);
            check("s6_filt",  32'(filt_out),   32'((j >= 4) ? 8'hFF : 8'h00));
            check("s6_pulse", 32'(edge_pulse), 32'((j == 4) ? 8'hFF : 8'h00));
        end
        // reset again, release, and interrupt the count one cycle short
        do_reset(8'hFF);
        for (int j = 0; j < 4; j++) step(1'b0, 8'hFF, 4'd2, 8'hFF, '0, '0);
        for (int j = 0; j < 2; j++) begin
            step(1'b1, 8'hFF, 4'd2, 8'hFF, '0, '0);
            check("s6_midrst", 32'({filt_out, edge_pulse, edge_flags, irq}), 32'd0);
        end
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 8'hFF, 4'd2, 8'hFF, '0, '0);
            check("s6_rel_filt",  32'(filt_out),   32'((j >= 4) ? 8'hFF : 8'h00));
            check("s6_rel_pulse", 32'(edge_pulse), 32'((j == 4) ? 8'hFF : 8'h00));
        end

        // Randomized traffic against the model
        do_reset('0);
        d = '0; r_th = 4'd2; r_re = 8'hFF; r_fe = 8'hFF;
        for (int j = 0; j < 1500; j++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
            if ($urandom_range(0, 40) == 0) r_th = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 30) == 0) begin
                r_re = W'($urandom);
                r_fe = W'($urandom);
            end
            r_clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            r_rst = ($urandom_range(0, 150) == 0);
            step(r_rst, d, r_th, r_re, r_fe, r_clr);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
